encoder8to3_event_serializer: RTL and testbench

Reverse direction of the team's 3-to-8 decoders. Captures one-hot or multi-hot event bits on an 8-bit input and queues them in a sticky pending register. Drains them as 3-bit binary indices, one per valid/ready transaction, in fixed priority order with the lowest index first. Sits between event sources and any consumer that takes an encoded index, e.g. a downstream 3-to-8 decoder.

---
 rtl/encoder8to3_event_serializer.sv | 120 ++++++++++++
 tb/tb_encoder8to3_event_serializer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder8to3_event_serializer.sv
// encoder8to3_event_serializer
// Captures event bits into a sticky pending register. Drains them as binary
// indices, lowest index first, over a valid/ready output stage.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   en           capture enable; when low `in` is ignored and draining continues
//   in           event bits, sampled each cycle when en=1
//   out          encoded index of the event being presented
//   out_valid    out holds a valid index
//   out_ready    consumer accepts out
//   pending      events captured but not yet loaded into the output stage
//   multi        pending has two or more bits set (combinational)
//   overflow     one-cycle pulse: an event hit a bit that was already pending
//   overflow_cnt saturating count of overflow pulses
//
// Output stage states:
//   state | meaning
//   EMPTY | out_valid=0, nothing presented; any pending bit loads next edge
//   FULL  | out_valid=1, out held stable until out_ready
module encoder8to3_event_serializer #(
  parameter int N     = 8,
  parameter int W     = $clog2(N),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     in,
  output logic [W-1:0]     out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     pending,
  output logic             multi,
  output logic             overflow,
  output logic [CNT_W-1:0] overflow_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     out_q, out_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     low_onehot;
  logic [N-1:0]     load_mask;
  logic [W-1:0]     low_idx;
  logic             found;
  logic             load;
  logic             ovf_d;
  logic [CNT_W-1:0] cnt_q;

  // Lowest-set-bit priority encode and its one-hot form.
  always_comb begin
    low_idx    = '0;
    low_onehot = '0;
    found      = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && pending_q[i]) begin
        found         = 1'b1;
        low_idx       = W'(i);
        low_onehot[i] = 1'b1;
      end
    end
  end

  assign load      = ((state_q == EMPTY) || out_ready) && found;
  assign load_mask = load ? low_onehot : '0;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    case (state_q)
      EMPTY: begin
        if (found) begin
          state_d = FULL;
          out_d   = low_idx;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (found) out_d   = low_idx;
          else       state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // A bit re-arriving in its own load cycle is a fresh event, not an overflow,
  // hence the ~load_mask in both terms.
  always_comb begin
    pending_d = (pending_q & ~load_mask) | (en ? in : '0);
    ovf_d     = en && (|(in & pending_q & ~load_mask));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      out_q     <= '0;
      pending_q <= '0;
      overflow  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      pending_q <= pending_d;
      overflow  <= ovf_d;
      if (ovf_d && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out          = out_q;
  assign out_valid    = (state_q == FULL);
  assign pending      = pending_q;
  assign overflow_cnt = cnt_q;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi        = |(pending_q & (pending_q - 1'b1));

endmodule

// File: tb/tb_encoder8to3_event_serializer.sv
module tb_encoder8to3_event_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] in;
  logic [2:0] out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pending;
  logic       multi;
  logic       overflow;
  logic [7:0] overflow_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encoder8to3_event_serializer dut (
    .clk(clk), .rst(rst), .en(en), .in(in),
    .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .pending(pending), .multi(multi),
    .overflow(overflow), .overflow_cnt(overflow_cnt)
  );

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; in = 8'hFF; out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({pending, out_valid, out, overflow, overflow_cnt} !== {8'h00, 1'b0, 3'd0, 1'b0, 8'd0}) begin
        errors++;
        $display("FAIL reset_cycle%0d: pending=%h valid=%b out=%0d ovf=%b cnt=%0d, want 00/0/0/0/0",
                 c, pending, out_valid, out, overflow, overflow_cnt);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({pending, out_valid, multi} !== {8'hFF, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_first_capture: pending=%h valid=%b multi=%b, want ff/0/1", pending, out_valid, multi);
    end
    in = 8'h00; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({out_valid, out} !== {1'b1, 3'(i)}) begin
        errors++;
        $display("FAIL reset_drain%0d: valid=%b out=%0d, want 1/%0d", i, out_valid, out, i);
      end
    end
    tick();
    checks++;
    if ({out_valid, pending} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_drain_end: valid=%b pending=%h, want 0/00", out_valid, pending);
    end
  endtask

  task automatic test_single();
    en = 1'b1; out_ready = 1'b1; in = 8'b0010_0000;
    tick();
    checks++;
    if ({pending, out_valid} !== {8'h20, 1'b0}) begin
      errors++;
      $display("FAIL single_capture: pending=%h valid=%b, want 20/0", pending, out_valid);
    end
    in = 8'h00;
    tick();
    checks++;
    if ({out_valid, out, pending} !== {1'b1, 3'd5, 8'h00}) begin
      errors++;
      $display("FAIL single_out: valid=%b out=%0d pending=%h, want 1/5/00", out_valid, out, pending);
    end
    tick();
    checks++;
    if ({out_valid, out} !== {1'b0, 3'd5}) begin
      errors++;
      $display("FAIL single_empty: valid=%b out=%0d, want 0/5 (out holds)", out_valid, out);
    end
  endtask

  task automatic test_multi_drain();
    logic [2:0] exp_out [4]  = '{3'd1, 3'd2, 3'd4, 3'd7};
    logic [7:0] exp_pend [4] = '{8'h94, 8'h90, 8'h80, 8'h00};
    logic       exp_multi [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    en = 1'b1; out_ready = 1'b1; in = 8'b1001_0110;
    tick();
    checks++;
    if ({pending, multi, out_valid} !== {8'h96, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL drain_capture: pending=%h multi=%b valid=%b, want 96/1/0", pending, multi, out_valid);
    end
    in = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({out_valid, out, pending, multi} !== {1'b1, exp_out[i], exp_pend[i], exp_multi[i]}) begin
        errors++;
        $display("FAIL drain_step%0d: valid=%b out=%0d pending=%h multi=%b, want 1/%0d/%h/%b",
                 i, out_valid, out, pending, multi, exp_out[i], exp_pend[i], exp_multi[i]);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    en = 1'b1; out_ready = 1'b0; in = 8'b0000_1000;
    tick();
    in = 8'h00;
    tick();
    checks++;
    if ({out_valid, out, pending} !== {1'b1, 3'd3, 8'h00}) begin
      errors++;
      $display("FAIL bp_load: valid=%b out=%0d pending=%h, want 1/3/00", out_valid, out, pending);
    end
    in = 8'b0000_0001;
    for (int c = 0; c < 5; c++) begin
      tick();
      in = 8'h00;
      checks++;
      if ({out_valid, out, pending, overflow} !== {1'b1, 3'd3, 8'h01, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b out=%0d pending=%h ovf=%b, want 1/3/01/0",
                 c, out_valid, out, pending, overflow);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, out, pending} !== {1'b1, 3'd0, 8'h00}) begin
      errors++;
      $display("FAIL bp_release: valid=%b out=%0d pending=%h, want 1/0/00", out_valid, out, pending);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    en = 1'b1; out_ready = 1'b0; in = 8'h01;
    tick();
    in = 8'h00;
    tick();
    in = 8'h40;
    tick();
    checks++;
    if ({pending, overflow, overflow_cnt} !== {8'h40, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL ovf_first: pending=%h ovf=%b cnt=%0d, want 40/0/0", pending, overflow, overflow_cnt);
    end
    tick();
    checks++;
    if ({pending, overflow, overflow_cnt} !== {8'h40, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL ovf_hit: pending=%h ovf=%b cnt=%0d, want 40/1/1", pending, overflow, overflow_cnt);
    end
    in = 8'h00;
    tick();
    checks++;
    if ({overflow, overflow_cnt, out, out_valid} !== {1'b0, 8'd1, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL ovf_pulse_end: ovf=%b cnt=%0d out=%0d valid=%b, want 0/1/0/1",
               overflow, overflow_cnt, out, out_valid);
    end
    in = 8'h40;
    for (int c = 0; c < 299; c++) tick();
    checks++;
    if ({overflow, overflow_cnt} !== {1'b1, 8'd255}) begin
      errors++;
      $display("FAIL ovf_saturate: ovf=%b cnt=%0d, want 1/255", overflow, overflow_cnt);
    end
    in = 8'h00;
    tick();
    checks++;
    if ({overflow, overflow_cnt} !== {1'b0, 8'd255}) begin
      errors++;
      $display("FAIL ovf_sat_hold: ovf=%b cnt=%0d, want 0/255", overflow, overflow_cnt);
    end
    // Bit 6 loads this edge while the same bit arrives again.
    out_ready = 1'b1; in = 8'h40;
    tick();
    checks++;
    if ({out_valid, out, pending, overflow} !== {1'b1, 3'd6, 8'h40, 1'b0}) begin
      errors++;
      $display("FAIL ovf_load_cycle: valid=%b out=%0d pending=%h ovf=%b, want 1/6/40/0",
               out_valid, out, pending, overflow);
    end
    in = 8'h00;
    tick();
    checks++;
    if ({out_valid, out, pending} !== {1'b1, 3'd6, 8'h00}) begin
      errors++;
      $display("FAIL ovf_repend_drain: valid=%b out=%0d pending=%h, want 1/6/00", out_valid, out, pending);
    end
    tick();
  endtask

  task automatic test_en_off();
    en = 1'b1; out_ready = 1'b0; in = 8'h0C;
    tick();
    en = 1'b0; in = 8'hFF;
    tick();
    checks++;
    if ({out_valid, out, pending, overflow} !== {1'b1, 3'd2, 8'h08, 1'b0}) begin
      errors++;
      $display("FAIL en0_hold: valid=%b out=%0d pending=%h ovf=%b, want 1/2/08/0",
               out_valid, out, pending, overflow);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, out, pending, overflow} !== {1'b1, 3'd3, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL en0_drain: valid=%b out=%0d pending=%h ovf=%b, want 1/3/00/0",
               out_valid, out, pending, overflow);
    end
    tick();
    checks++;
    if ({out_valid, pending} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL en0_end: valid=%b pending=%h, want 0/00", out_valid, pending);
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; out_ready = 1'b0; in = 8'h03;
    tick();
    in = 8'h00;
    tick();
    rst = 1'b1; out_ready = 1'b1; in = 8'hFF;
    tick();
    checks++;
    if ({out_valid, out, pending, overflow_cnt} !== {1'b0, 3'd0, 8'h00, 8'd0}) begin
      errors++;
      $display("FAIL rst_mid: valid=%b out=%0d pending=%h cnt=%0d, want 0/0/00/0",
               out_valid, out, pending, overflow_cnt);
    end
    rst = 1'b0; in = 8'h00;
    tick();
    checks++;
    if ({out_valid, pending} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL rst_mid_after: valid=%b pending=%h, want 0/00", out_valid, pending);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in = 8'h00; out_ready = 1'b0;
    test_reset();
    test_single();
    test_multi_drain();
    test_backpressure();
    test_overflow();
    test_en_off();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
